// File: rtl/wb_commit_multi.sv
// Writeback/commit stage: holds one bundle of LANES instructions and commits it in order.
// Precise exceptions, ERET and serialising ops flush the pipe; register writes go to a golden-trace FIFO.
module wb_commit_multi #(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8,
  parameter int DATA_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [LANES*DATA_W-1:0] in_pc,
  input  logic [LANES*4-1:0]      in_rf_we,
  input  logic [LANES*5-1:0]      in_dest,
  input  logic [LANES*DATA_W-1:0] in_result,
  input  logic [LANES-1:0]        in_ex,
  input  logic [LANES*5-1:0]      in_exccode,
  input  logic [LANES*DATA_W-1:0] in_badvaddr,
  input  logic [2:0]              in_c0_op,
  input  logic [7:0]              in_c0_addr,
  input  logic                    in_serial,
  input  logic [DATA_W-1:0]       cp0_rdata,
  output logic [LANES*4-1:0]      rf_we,
  output logic [LANES*5-1:0]      rf_waddr,
  output logic [LANES*DATA_W-1:0] rf_wdata,
  output logic [LANES*5-1:0]      fwd_dest,
  output logic [LANES*DATA_W-1:0] fwd_result,
  output logic                    cp0_we,
  output logic [7:0]              cp0_addr,
  output logic [DATA_W-1:0]       cp0_wdata,
  output logic                    exc_valid,
  output logic [DATA_W-1:0]       exc_pc,
  output logic [4:0]              exc_code,
  output logic [DATA_W-1:0]       exc_badvaddr,
  output logic                    eret,
  output logic                    serial_op,
  output logic                    pipeline_flush,
  output logic                    debug_wb_valid,
  output logic [DATA_W-1:0]       debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [DATA_W-1:0]       debug_wb_rf_wdata
);

  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic                    ws_valid;
  logic [LANES-1:0]        ws_lane_valid;
  logic [LANES*DATA_W-1:0] ws_pc;
  logic [LANES*4-1:0]      ws_we;
  logic [LANES*5-1:0]      ws_dest;
  logic [LANES*DATA_W-1:0] ws_result;
  logic [LANES-1:0]        ws_ex;
  logic [LANES*5-1:0]      ws_exccode;
  logic [LANES*DATA_W-1:0] ws_badvaddr;
  logic [2:0]              ws_c0_op;
  logic [7:0]              ws_c0_addr;
  logic                    ws_serial;

  logic [LANES-1:0]  live;
  logic [LANES-1:0]  lane_ok;
  logic              kill_seen;
  logic              kill_ex;
  logic [DATA_W-1:0] kill_pc;
  logic [4:0]        kill_code;
  logic [DATA_W-1:0] kill_badvaddr;

  logic [3:0]        wen   [LANES];
  logic [DATA_W-1:0] wdata [LANES];
  logic [PW-1:0]     slot  [LANES];
  logic [CW-1:0]     n_push;

  logic [DATA_W-1:0] tf_pc   [TRACE_DEPTH];
  logic [3:0]        tf_wen  [TRACE_DEPTH];
  logic [4:0]        tf_num  [TRACE_DEPTH];
  logic [DATA_W-1:0] tf_data [TRACE_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [CW:0]       avail;
  logic              fifo_ne;
  logic              commit_fire;
  logic              flush;

  assign live = ws_lane_valid & {LANES{ws_valid}};

  // lane_ok[i] is true when no older lane kills the bundle (i <= kill lane)
  always_comb begin
    kill_seen     = 1'b0;
    kill_ex       = 1'b0;
    kill_pc       = '0;
    kill_code     = '0;
    kill_badvaddr = '0;
    lane_ok       = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_ok[i] = !kill_seen;
      if (!kill_seen && live[i] &&
          (ws_ex[i] || (i == 0 && (ws_c0_op[0] || ws_serial)))) begin
        kill_seen     = 1'b1;
        kill_ex       = ws_ex[i];
        kill_pc       = ws_pc[i*DATA_W +: DATA_W];
        kill_code     = ws_exccode[i*5 +: 5];
        kill_badvaddr = ws_badvaddr[i*DATA_W +: DATA_W];
      end
    end
  end

  // Surviving writes get consecutive FIFO slots in ascending lane order
  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata[i] = ws_result[i*DATA_W +: DATA_W];
      if (i == 0 && ws_c0_op[2]) wdata[i] = cp0_rdata;
      wen[i]  = (live[i] && lane_ok[i] && !ws_ex[i]) ? ws_we[i*4 +: 4] : 4'h0;
      slot[i] = wr_ptr + n_push[PW-1:0];
      if (|wen[i]) n_push = n_push + CW'(1);
    end
  end

  assign fifo_ne     = (count != '0);
  assign free        = CW'(TRACE_DEPTH) - count;
  assign avail       = {1'b0, free} + {{CW{1'b0}}, fifo_ne};
  assign commit_fire = ws_valid && (avail >= {1'b0, n_push});
  assign flush       = commit_fire && kill_seen;
  assign in_ready    = !flush && (!ws_valid || commit_fire);

  always_comb begin
    rf_we    = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      rf_we[i*4 +: 4]         = commit_fire ? wen[i] : 4'h0;
      rf_waddr[i*5 +: 5]      = live[i] ? ws_dest[i*5 +: 5] : 5'd0;
      rf_wdata[i*DATA_W +: DATA_W] = live[i] ? wdata[i] : '0;
    end
  end

  assign fwd_dest   = rf_waddr;
  assign fwd_result = rf_wdata;

  assign cp0_we    = commit_fire && live[0] && ws_c0_op[1] && !ws_ex[0];
  assign cp0_addr  = live[0] ? ws_c0_addr : 8'h00;
  assign cp0_wdata = live[0] ? ws_result[DATA_W-1:0] : '0;

  // An exception on the kill lane outranks ERET, which outranks a serialising op
  assign pipeline_flush = flush;
  assign exc_valid      = flush && kill_ex;
  assign exc_pc         = exc_valid ? kill_pc : '0;
  assign exc_code       = exc_valid ? kill_code : 5'd0;
  assign exc_badvaddr   = exc_valid ? kill_badvaddr : '0;
  assign eret           = flush && !kill_ex && ws_c0_op[0];
  assign serial_op      = flush && !kill_ex && !ws_c0_op[0] && ws_serial;

  assign debug_wb_valid    = fifo_ne;
  assign debug_wb_pc       = fifo_ne ? tf_pc[rd_ptr] : '0;
  assign debug_wb_rf_wen   = fifo_ne ? tf_wen[rd_ptr] : 4'h0;
  assign debug_wb_rf_wnum  = fifo_ne ? tf_num[rd_ptr] : 5'd0;
  assign debug_wb_rf_wdata = fifo_ne ? tf_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (commit_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (|wen[i]) begin
          tf_pc[slot[i]]   <= ws_pc[i*DATA_W +: DATA_W];
          tf_wen[slot[i]]  <= wen[i];
          tf_num[slot[i]]  <= ws_dest[i*5 +: 5];
          tf_data[slot[i]] <= wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid      <= 1'b0;
      ws_lane_valid <= '0;
      ws_pc         <= '0;
      ws_we         <= '0;
      ws_dest       <= '0;
      ws_result     <= '0;
      ws_ex         <= '0;
      ws_exccode    <= '0;
      ws_badvaddr   <= '0;
      ws_c0_op      <= '0;
      ws_c0_addr    <= '0;
      ws_serial     <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else begin
      if (flush)         ws_valid <= 1'b0;
      else if (in_ready) ws_valid <= in_valid;
      if (in_valid && in_ready) begin
        ws_lane_valid <= in_lane_valid;
        ws_pc         <= in_pc;
        ws_we         <= in_rf_we;
        ws_dest       <= in_dest;
        ws_result     <= in_result;
        ws_ex         <= in_ex;
        ws_exccode    <= in_exccode;
        ws_badvaddr   <= in_badvaddr;
        ws_c0_op      <= in_c0_op;
        ws_c0_addr    <= in_c0_addr;
        ws_serial     <= in_serial;
      end
      if (commit_fire) wr_ptr <= wr_ptr + n_push[PW-1:0];
      if (fifo_ne)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + (commit_fire ? n_push : '0) - CW'(fifo_ne);
    end
  end

endmodule

// File: tb/tb_wb_commit_multi.sv
// Directed bench for wb_commit_multi: commit/flush checks per step, trace port checked against a scoreboard.
module tb_wb_commit_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  in_lane_valid;
  logic [63:0] in_pc, in_result, in_badvaddr;
  logic [7:0]  in_rf_we;
  logic [9:0]  in_dest, in_exccode;
  logic [1:0]  in_ex;
  logic [2:0]  in_c0_op;
  logic [7:0]  in_c0_addr;
  logic        in_serial;
  logic [31:0] cp0_rdata;
  logic [7:0]  rf_we;
  logic [9:0]  rf_waddr, fwd_dest;
  logic [63:0] rf_wdata, fwd_result;
  logic        cp0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        exc_valid;
  logic [31:0] exc_pc, exc_badvaddr;
  logic [4:0]  exc_code;
  logic        eret, serial_op, pipeline_flush;
  logic        debug_wb_valid;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;

  wb_commit_multi #(.LANES(2), .TRACE_DEPTH(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_pc(in_pc), .in_rf_we(in_rf_we), .in_dest(in_dest),
    .in_result(in_result), .in_ex(in_ex), .in_exccode(in_exccode), .in_badvaddr(in_badvaddr),
    .in_c0_op(in_c0_op), .in_c0_addr(in_c0_addr), .in_serial(in_serial), .cp0_rdata(cp0_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_dest(fwd_dest),
    .fwd_result(fwd_result), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .serial_op(serial_op), .pipeline_flush(pipeline_flush),
    .debug_wb_valid(debug_wb_valid), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  num;
    logic [31:0] data;
  } tr_t;

  tr_t exp_q[$];
  tr_t pend_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_trace(input logic [31:0] pc, input logic [4:0] num, input logic [31:0] data);
    tr_t t;
    t.pc = pc; t.wen = 4'hF; t.num = num; t.data = data;
    pend_q.push_back(t);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_lane_valid = '0; in_pc = '0; in_rf_we = '0; in_dest = '0;
    in_result = '0; in_ex = '0; in_exccode = '0; in_badvaddr = '0; in_c0_op = '0;
    in_c0_addr = '0; in_serial = 1'b0; cp0_rdata = '0;
  endtask

  task automatic set_b(input logic [1:0] lv, input logic [31:0] pc0, input logic [3:0] we0, input logic [3:0] we1,
                       input logic [4:0] d0, input logic [4:0] d1, input logic [31:0] r0, input logic [31:0] r1);
    idle();
    in_valid = 1'b1; in_lane_valid = lv; in_pc = {pc0 + 32'd4, pc0}; in_rf_we = {we1, we0};
    in_dest = {d1, d0}; in_result = {r1, r0};
  endtask

  // Checks the trace head against the scoreboard, then advances one clock
  task automatic cycle();
    tr_t h;
    if (exp_q.size() != 0) begin
      h = exp_q.pop_front();
      chk("trace_valid", debug_wb_valid, 1);
      chk("trace_pc", debug_wb_pc, h.pc);
      chk("trace_wen", debug_wb_rf_wen, h.wen);
      chk("trace_wnum", debug_wb_rf_wnum, h.num);
      chk("trace_wdata", debug_wb_rf_wdata, h.data);
    end else begin
      chk("trace_idle", debug_wb_valid, 0);
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
    end else begin
      while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
    chk("drain_bound", exp_q.size(), 0);
    cycle();
  endtask

  // Back-to-back 2-write bundles from an empty FIFO: bundles 1..7 commit at once,
  // bundle 8 finds the FIFO full (8 entries) and stalls exactly one cycle.
  task automatic run_stream(input logic [31:0] base, input bit rst_at_stall);
    int b;
    int nxt;
    bit fire;
    logic [4:0] e0, e1;
    set_b(2'b11, base + 32'd16, 4'hF, 4'hF, 5'd1, 5'd11, base + 32'd1, base + 32'h101);
    #1;
    chk("stream_first_ready", in_ready, 1);
    cycle();
    b = 1;
    for (int s = 1; s <= 9; s++) begin
      nxt = b + 1;
      if (nxt <= 8)
        set_b(2'b11, base + 32'(16 * nxt), 4'hF, 4'hF, 5'(nxt), 5'(nxt + 10),
              base + 32'(nxt), base + 32'h100 + 32'(nxt));
      else
        idle();
      if (rst_at_stall && s == 8) reset = 1'b1;
      #1;
      fire = (s != 8);
      e0 = 5'(b);
      e1 = 5'(b + 10);
      chk("stream_ready", in_ready, fire);
      chk("stream_rf_we", rf_we, fire ? 8'hFF : 8'h00);
      chk("stream_fwd_dest", fwd_dest, {e1, e0});
      if (fire) begin
        expect_trace(base + 32'(16 * b), e0, base + 32'(b));
        expect_trace(base + 32'(16 * b) + 32'd4, e1, base + 32'h100 + 32'(b));
        b++;
      end
      cycle();
      if (rst_at_stall && s == 8) break;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_fwd_dest", fwd_dest, 0);
    chk("rst_flush", pipeline_flush, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_cp0_we", cp0_we, 0);
    cycle();

    // two live lanes, both write
    set_b(2'b11, 32'h100, 4'hF, 4'hF, 5'd3, 5'd4, 32'h11, 32'h22);
    #1;
    chk("b1_accept", in_ready, 1);
    cycle();
    idle();
    #1;
    chk("b1_rf_we", rf_we, 8'hFF);
    chk("b1_waddr", rf_waddr, {5'd4, 5'd3});
    chk("b1_wdata", rf_wdata, {32'h22, 32'h11});
    chk("b1_ready", in_ready, 1);
    chk("b1_flush", pipeline_flush, 0);
    expect_trace(32'h100, 5'd3, 32'h11);
    expect_trace(32'h104, 5'd4, 32'h22);
    cycle();
    chk("b1_after_we", rf_we, 0);

    // lane 1 exception
    set_b(2'b11, 32'h200, 4'hF, 4'hF, 5'd5, 5'd6, 32'h55, 32'h66);
    in_ex = 2'b10; in_exccode = {5'h04, 5'h00}; in_badvaddr = {32'h1001, 32'h0};
    #1;
    cycle();
    idle();
    #1;
    chk("ex1_rf_we", rf_we, 8'h0F);
    chk("ex1_valid", exc_valid, 1);
    chk("ex1_pc", exc_pc, 32'h204);
    chk("ex1_code", exc_code, 5'h04);
    chk("ex1_badva", exc_badvaddr, 32'h1001);
    chk("ex1_flush", pipeline_flush, 1);
    chk("ex1_ready", in_ready, 0);
    expect_trace(32'h200, 5'd5, 32'h55);
    cycle();
    chk("ex1_next_flush", pipeline_flush, 0);
    chk("ex1_next_exc", exc_valid, 0);
    chk("ex1_next_ready", in_ready, 1);
    chk("ex1_next_fwd", fwd_dest, 0);

    // lane 0 exception overriding an ERET, lane 1 would write
    set_b(2'b11, 32'h300, 4'hF, 4'hF, 5'd2, 5'd7, 32'h33, 32'h77);
    in_ex = 2'b01; in_exccode = {5'h00, 5'h0A}; in_badvaddr = {32'h0, 32'h300}; in_c0_op = 3'b001;
    #1;
    cycle();
    idle();
    #1;
    chk("ex0_rf_we", rf_we, 0);
    chk("ex0_valid", exc_valid, 1);
    chk("ex0_pc", exc_pc, 32'h300);
    chk("ex0_code", exc_code, 5'h0A);
    chk("ex0_badva", exc_badvaddr, 32'h300);
    chk("ex0_eret", eret, 0);
    chk("ex0_flush", pipeline_flush, 1);
    cycle();

    // ERET on lane 0: lane 0 still writes, lane 1 dropped
    set_b(2'b11, 32'h400, 4'hF, 4'hF, 5'd9, 5'd10, 32'h99, 32'hAA);
    in_c0_op = 3'b001;
    #1;
    cycle();
    idle();
    #1;
    chk("eret_rf_we", rf_we, 8'h0F);
    chk("eret_pulse", eret, 1);
    chk("eret_flush", pipeline_flush, 1);
    chk("eret_exc", exc_valid, 0);
    chk("eret_serial", serial_op, 0);
    expect_trace(32'h400, 5'd9, 32'h99);
    cycle();

    // MFC0 on lane 0 only
    set_b(2'b01, 32'h600, 4'hF, 4'hF, 5'd8, 5'd13, 32'h1234, 32'h5678);
    in_c0_op = 3'b100;
    #1;
    cycle();
    idle();
    cp0_rdata = 32'hDEADBEEF;
    #1;
    chk("mfc0_wdata", rf_wdata[31:0], 32'hDEADBEEF);
    chk("mfc0_rf_we", rf_we, 8'h0F);
    chk("mfc0_fwd_dest", fwd_dest, {5'd0, 5'd8});
    chk("mfc0_cp0_we", cp0_we, 0);
    expect_trace(32'h600, 5'd8, 32'hDEADBEEF);
    cycle();
    cp0_rdata = '0;

    // MTC0 on lane 0
    set_b(2'b01, 32'h700, 4'h0, 4'h0, 5'd0, 5'd0, 32'hCAFE, 32'h0);
    in_c0_op = 3'b010; in_c0_addr = 8'h60;
    #1;
    cycle();
    idle();
    #1;
    chk("mtc0_we", cp0_we, 1);
    chk("mtc0_addr", cp0_addr, 8'h60);
    chk("mtc0_wdata", cp0_wdata, 32'hCAFE);
    chk("mtc0_rf_we", rf_we, 0);
    chk("mtc0_flush", pipeline_flush, 0);
    cycle();

    // serialising op on lane 0, lane 1 live
    set_b(2'b11, 32'h500, 4'hF, 4'hF, 5'd11, 5'd12, 32'hAA, 32'hBB);
    in_serial = 1'b1;
    #1;
    cycle();
    idle();
    #1;
    chk("ser_rf_we", rf_we, 8'h0F);
    chk("ser_op", serial_op, 1);
    chk("ser_flush", pipeline_flush, 1);
    chk("ser_eret", eret, 0);
    chk("ser_exc", exc_valid, 0);
    chk("ser_ready", in_ready, 0);
    expect_trace(32'h500, 5'd11, 32'hAA);
    cycle();
    chk("ser_next_we", rf_we, 0);
    chk("ser_next_op", serial_op, 0);

    drain();
    run_stream(32'h1000, 1'b0);
    drain();

    // stall again, then reset while the bundle is held
    run_stream(32'h2000, 1'b1);
    reset = 1'b0;
    idle();
    #1;
    chk("rst2_ready", in_ready, 1);
    chk("rst2_rf_we", rf_we, 0);
    chk("rst2_fwd_dest", fwd_dest, 0);
    chk("rst2_trace", debug_wb_valid, 0);
    chk("rst2_flush", pipeline_flush, 0);
    cycle();

    set_b(2'b01, 32'h3000, 4'h3, 4'h0, 5'd21, 5'd0, 32'h3021, 32'h0);
    #1;
    cycle();
    idle();
    #1;
    chk("post_rst_rf_we", rf_we, 8'h03);
    begin
      tr_t t;
      t.pc = 32'h3000; t.wen = 4'h3; t.num = 5'd21; t.data = 32'h3021;
      pend_q.push_back(t);
    end
    cycle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
